// File: rtl/switch_send_queue_pkg.sv
// Shared Switch types and helpers: message layout and destination-index width derivation.
// Payload elements carry IEEE-754 single-precision bit patterns so storage stays plain logic.
package switch_send_queue_pkg;

    localparam int unsigned MSG_WIDTH        = 2;
    localparam int unsigned SWITCH_CORE_SIZE = 3;

    typedef logic [31:0] sreal_t;

    function automatic int unsigned core_addr_size(input int unsigned core_size);
        return (core_size > 1) ? $clog2(core_size) : 1;
    endfunction

    localparam int unsigned MSG_CORE_ADDR_SIZE = core_addr_size(SWITCH_CORE_SIZE);

    typedef struct {
        logic [MSG_CORE_ADDR_SIZE-1:0] core_idx;
        sreal_t                        data [MSG_WIDTH];
    } msg_t;

endpackage

// File: rtl/switch_send_queue.sv
// Per-core outbound message queue feeding one Switch send port; holds the head until send_ok.
module switch_send_queue
    import switch_send_queue_pkg::*;
#(
    parameter int unsigned WIDTH          = MSG_WIDTH,
    parameter int unsigned CORE_SIZE      = SWITCH_CORE_SIZE,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned CORE_ADDR_SIZE = core_addr_size(CORE_SIZE),
    parameter int unsigned COUNT_SIZE     = $clog2(DEPTH + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      enq_valid,
    output logic                      enq_ready,
    input  logic [CORE_ADDR_SIZE-1:0] enq_core_idx,
    input  sreal_t                    enq_data [WIDTH],
    output logic                      send_ready,
    output logic [CORE_ADDR_SIZE-1:0] send_core_idx,
    output sreal_t                    send_data [WIDTH],
    input  logic                      send_ok,
    output logic [COUNT_SIZE-1:0]     count,
    output logic                      drop_err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]          LAST_PTR   = PTR_W'(DEPTH - 1);
    localparam logic [COUNT_SIZE-1:0]     FULL_COUNT = COUNT_SIZE'(DEPTH);
    localparam logic [CORE_ADDR_SIZE:0]   CORE_LIMIT = (CORE_ADDR_SIZE + 1)'(CORE_SIZE);

    logic [CORE_ADDR_SIZE-1:0] core_mem [DEPTH];
    sreal_t                    data_mem [DEPTH][WIDTH];
    logic [PTR_W-1:0]          rd_ptr;
    logic [PTR_W-1:0]          wr_ptr;

    logic enq_handshake;
    logic idx_ok;
    logic do_enq;
    logic do_deq;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign enq_ready     = (count < FULL_COUNT);
    assign send_ready    = (count != '0);
    assign enq_handshake = enq_valid && enq_ready;
    assign idx_ok        = ({1'b0, enq_core_idx} < CORE_LIMIT);
    assign do_enq        = enq_handshake && idx_ok;
    assign do_deq        = send_ready && send_ok;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            drop_err <= 1'b0;
        end else begin
            drop_err <= enq_handshake && !idx_ok;
            if (do_enq) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_deq) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked solely by count and the pointers.
    always_ff @(posedge clock) begin
        if (!reset && !flush && do_enq) begin
            core_mem[wr_ptr] <= enq_core_idx;
            data_mem[wr_ptr] <= enq_data;
        end
    end

    always_comb begin
        send_core_idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            send_data[i] = '0;
        end
        if (send_ready) begin
            send_core_idx = core_mem[rd_ptr];
            for (int unsigned i = 0; i < WIDTH; i++) begin
                send_data[i] = data_mem[rd_ptr][i];
            end
        end
    end

endmodule

// File: tb/tb_switch_send_queue.sv
// Directed bench for switch_send_queue: vector table plus a wrap/simultaneous sequence.
module tb_switch_send_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    logic [1:0]  enq_core_idx = '0;
    logic [31:0] enq_data [2];
    logic        send_ready;
    logic [1:0]  send_core_idx;
    logic [31:0] send_data [2];
    logic        send_ok = 1'b0;
    logic [2:0]  count;
    logic        drop_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    switch_send_queue #(
        .WIDTH(2),
        .CORE_SIZE(3),
        .DEPTH(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .enq_valid(enq_valid),
        .enq_ready(enq_ready),
        .enq_core_idx(enq_core_idx),
        .enq_data(enq_data),
        .send_ready(send_ready),
        .send_core_idx(send_core_idx),
        .send_data(send_data),
        .send_ok(send_ok),
        .count(count),
        .drop_err(drop_err)
    );

    typedef struct {
        logic       rst, fl, ev;
        logic [1:0] ci;
        int         a, b;
        logic       ok;
        logic       er, sr;
        logic [1:0] si;
        int         sa, sb, cnt;
        logic       de;
    } vec_t;

    typedef struct {
        int ci, a, b;
    } msg_m;

    vec_t tbl [$];
    msg_m model [$];

    // Small non-negative integer to single-precision bit pattern.
    function automatic logic [31:0] fp(input int n);
        int e;
        if (n == 0) return '0;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
    endfunction

    function automatic vec_t v(input logic rst, fl, ev, input int ci, a, b, input logic ok,
                               input logic er, sr, input int si, sa, sb, cnt, input logic de);
        vec_t r;
        r.rst = rst; r.fl = fl; r.ev = ev; r.ci = 2'(ci); r.a = a; r.b = b; r.ok = ok;
        r.er = er; r.sr = sr; r.si = 2'(si); r.sa = sa; r.sb = sb; r.cnt = cnt; r.de = de;
        return r;
    endfunction

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    task automatic check_out(input int step, input logic er, sr, input logic [1:0] si,
                             input int sa, sb, cnt, input logic de);
        chk("enq_ready", step, 32'(enq_ready), 32'(er));
        chk("send_ready", step, 32'(send_ready), 32'(sr));
        chk("send_core_idx", step, 32'(send_core_idx), 32'(si));
        chk("send_data0", step, send_data[0], fp(sa));
        chk("send_data1", step, send_data[1], fp(sb));
        chk("count", step, 32'(count), 32'(cnt));
        chk("drop_err", step, 32'(drop_err), 32'(de));
    endtask

    task automatic drive(input logic rst, fl, ev, input logic [1:0] ci, input int a, b, input logic ok);
        reset = rst; flush = fl; enq_valid = ev; enq_core_idx = ci;
        enq_data[0] = fp(a); enq_data[1] = fp(b); send_ok = ok;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int step;
        msg_m m;
        enq_data[0] = '0;
        enq_data[1] = '0;

        // Reset, idle, send_ok on empty queue
        tbl.push_back(v(1,0,0,0,0,0,0, 1,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 1,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,1, 1,0,0,0,0,0,0));
        // Single message held for 5 cycles, then acked
        tbl.push_back(v(0,0,1,1,11,13,0, 1,1,1,11,13,1,0));
        for (int i = 0; i < 4; i++) tbl.push_back(v(0,0,0,0,0,0,0, 1,1,1,11,13,1,0));
        tbl.push_back(v(0,0,0,0,0,0,1, 1,0,0,0,0,0,0));
        // Fill to DEPTH, refused 5th, full+ack+enq without pass-through, drain in order
        tbl.push_back(v(0,0,1,0,1,2,0, 1,1,0,1,2,1,0));
        tbl.push_back(v(0,0,1,1,3,4,0, 1,1,0,1,2,2,0));
        tbl.push_back(v(0,0,1,2,5,6,0, 1,1,0,1,2,3,0));
        tbl.push_back(v(0,0,1,0,7,8,0, 0,1,0,1,2,4,0));
        tbl.push_back(v(0,0,1,1,9,10,0, 0,1,0,1,2,4,0));
        tbl.push_back(v(0,0,1,1,9,10,1, 1,1,1,3,4,3,0));
        tbl.push_back(v(0,0,0,0,0,0,1, 1,1,2,5,6,2,0));
        tbl.push_back(v(0,0,0,0,0,0,1, 1,1,0,7,8,1,0));
        tbl.push_back(v(0,0,0,0,0,0,1, 1,0,0,0,0,0,0));
        // Bad destination: one-cycle drop_err, nothing queued
        tbl.push_back(v(0,0,1,3,20,21,0, 1,0,0,0,0,0,1));
        tbl.push_back(v(0,0,0,0,0,0,0, 1,0,0,0,0,0,0));
        // Three entries, then flush with enq and ack
        tbl.push_back(v(0,0,1,0,1,2,0, 1,1,0,1,2,1,0));
        tbl.push_back(v(0,0,1,1,3,4,0, 1,1,0,1,2,2,0));
        tbl.push_back(v(0,0,1,2,5,6,0, 1,1,0,1,2,3,0));
        tbl.push_back(v(0,1,1,0,7,8,1, 1,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,1, 1,0,0,0,0,0,0));
        // Same scenario with reset
        tbl.push_back(v(0,0,1,0,1,2,0, 1,1,0,1,2,1,0));
        tbl.push_back(v(0,0,1,1,3,4,0, 1,1,0,1,2,2,0));
        tbl.push_back(v(0,0,1,2,5,6,0, 1,1,0,1,2,3,0));
        tbl.push_back(v(1,0,1,0,7,8,1, 1,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,1, 1,0,0,0,0,0,0));
        // Flush in the cycle of a bad enqueue suppresses drop_err
        tbl.push_back(v(0,1,1,3,0,0,0, 1,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 1,0,0,0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].fl, tbl[i].ev, tbl[i].ci, tbl[i].a, tbl[i].b, tbl[i].ok);
            check_out(i, tbl[i].er, tbl[i].sr, tbl[i].si, tbl[i].sa, tbl[i].sb, tbl[i].cnt, tbl[i].de);
        end

        // Steady state at count=2 with enqueue and ack every cycle, across pointer wraps
        step = 100;
        for (int i = 0; i < 12; i++) begin
            logic ok;
            ok = (i >= 2);
            m.ci = i % 3; m.a = 40 + i; m.b = 60 + i;
            drive(1'b0, 1'b0, 1'b1, 2'(m.ci), m.a, m.b, ok);
            if (ok && model.size() > 0) void'(model.pop_front());
            model.push_back(m);
            check_out(step, 1'b1, 1'b1, 2'(model[0].ci), model[0].a, model[0].b,
                      (i < 2) ? i + 1 : 2, 1'b0);
            step++;
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 1'b1);
            void'(model.pop_front());
            if (model.size() > 0)
                check_out(step, 1'b1, 1'b1, 2'(model[0].ci), model[0].a, model[0].b, 1, 1'b0);
            else
                check_out(step, 1'b1, 1'b0, 2'd0, 0, 0, 0, 1'b0);
            step++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/switch_send_queue.md
Name: switch_send_queue

Overview:
- Per-core outbound message queue sitting directly upstream of one send port of the Switch.
- The core enqueues (destination core, WIDTH-element shortreal vector) messages at its own pace.
- The block presents the oldest message on the Switch send interface, holds it stable until the Switch acknowledges with send_ok, then advances.
- One instance per core; lets a core issue back-to-back sends without stalling on Switch arbitration.

Parameters:
- WIDTH, 2, shortreal elements per message (matches Switch WIDTH).
- CORE_SIZE, 3, number of cores on the Switch (matches Switch CORE_SIZE).
- DEPTH, 4, queue entries; any value >= 1, need not be a power of two.
- CORE_ADDR_SIZE, $clog2(CORE_SIZE), derived; destination index width.
- COUNT_SIZE, $clog2(DEPTH+1), derived; occupancy width.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous queue clear.
- enq_valid  in  1  core offers a message.
- enq_ready  out  1  queue can accept.
- enq_core_idx  in  CORE_ADDR_SIZE  destination core.
- enq_data  in  WIDTH x shortreal  payload.
- send_ready  out  1  to Switch: head message valid.
- send_core_idx  out  CORE_ADDR_SIZE  to Switch: head destination.
- send_data  out  WIDTH x shortreal  to Switch: head payload.
- send_ok  in  1  from Switch: head accepted this cycle.
- count  out  COUNT_SIZE  current occupancy.
- drop_err  out  1  one-cycle pulse: an enqueue was rejected for a bad destination.

Behaviour:
- Clock and reset: one clock, clock; reset is synchronous and active-high.
- Reset values (registered state): rd_ptr=0, wr_ptr=0, count=0, drop_err=0.
- Reset-derived outputs: enq_ready=1, send_ready=0, send_core_idx=0, send_data all 0.0.
- Reset mid-operation discards all queued entries; an enq offered in the reset cycle is not accepted.
- Enqueue:
  - Accepted on a posedge where enq_valid && enq_ready && enq_core_idx < CORE_SIZE.
  - Writes the entry at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
  - enq_ready = (count < DEPTH), decoded from registered count only. A full queue does not accept even if a dequeue happens the same cycle (no pass-through).
- Bad destination: enq_valid && enq_ready && enq_core_idx >= CORE_SIZE.
  - Entry is not written.
  - drop_err=1 in the following cycle only.
  - Only reachable when CORE_SIZE is not a power of two.
- Head presentation:
  - send_ready = (count != 0).
  - send_core_idx/send_data = entry at rd_ptr, combinational from storage.
  - Forced to 0 / 0.0 when empty.
  - Enqueue-to-send_ready latency is 1 cycle: an entry accepted at edge N is visible after edge N; no same-cycle bypass.
- Dequeue:
  - Occurs on a posedge where send_ready && send_ok; rd_ptr wraps DEPTH-1 -> 0.
  - send_ok while empty is ignored.
  - Head outputs stay stable while send_ready=1 and send_ok=0, for any number of cycles.
- Simultaneous enqueue and dequeue (count between 1 and DEPTH-1): both pointers advance and count is unchanged.
- Empty plus enqueue: count -> 1 and send_ready rises the next cycle.
- flush:
  - Pointers and count go to 0 at the edge.
  - Any enq or dequeue in that same cycle is discarded.
  - drop_err is cleared.
  - reset has priority over flush.
- count is always the number of valid entries, 0..DEPTH.

Decomposition:
- The switch package owns:
  - the msg_t typedef: packed core index plus unpacked shortreal[WIDTH] payload, as a struct;
  - the CORE_ADDR_SIZE derivation helper, shared with Switch.
- No sub-module: storage array, two pointers and a counter live in this module.
- A generic FIFO is not reused because of the flush, drop and zeroing rules.

Test Plan:
- Reset then idle -> enq_ready=1, send_ready=0, count=0, send_data={0.0,0.0}.
- Enqueue (idx=1, {11.0,13.0}) with send_ok=0 for 5 cycles -> send_ready=1 from the next cycle, outputs stable at 1/{11,13}, count=1. Then send_ok=1 for one cycle -> send_ready=0 and count=0 the cycle after.
- Enqueue 4 messages (idx 0,1,2,0; data {1,2},{3,4},{5,6},{7,8}) back-to-back, send_ok=0 -> count=4, enq_ready=0. A 5th enq is refused. Then send_ok held 1 -> outputs in order {1,2},{3,4},{5,6},{7,8}, one per cycle.
- Wrap and simultaneous: keep count=2 while enqueuing and acking every cycle for 10 cycles -> count stays 2, all 10 messages emerge in FIFO order across the pointer wrap.
- enq_core_idx=3 with CORE_SIZE=3 -> not queued, count unchanged, drop_err pulses for exactly 1 cycle.
- Queue holding 3 entries, then flush=1 together with enq_valid=1 and send_ok=1 -> count=0, send_ready=0 next cycle, nothing queued. Repeat the scenario with reset instead of flush -> identical result.
